// File: rtl/fir_pkg.sv
// Shared constants and width helpers for the parametrised FIR filter.
// Latency: n/a (package only).
// Backpressure: n/a.
package fir_pkg;

    // Sample-in to sample-out latency in clock cycles.
    localparam int FIR_LATENCY = 3;

    // Ceiling log2, minimum result 0; usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Accumulator width: one full product plus enough growth for TAPS terms.
    function automatic int acc_width(input int n, input int cw, input int taps);
        return n + cw + clog2(taps);
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up by FRAC bits, then clamp to a signed N-bit range.
// Latency: combinational.
// Backpressure: none.
module fir_round_sat #(
    parameter int AW   = 34,
    parameter int N    = 16,
    parameter int FRAC = 14
) (
    input  logic signed [AW-1:0] i_acc,
    output logic signed [N-1:0]  o_dat,
    output logic                 o_sat
);

    // One guard bit above the accumulator so adding the half LSB cannot wrap.
    localparam logic signed [AW:0] HALF = {{AW{1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [AW:0] MAXV = {{(AW - N + 2){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [AW:0] MINV = {{(AW - N + 2){1'b1}}, {(N - 1){1'b0}}};

    logic signed [AW:0] w_rnd;
    logic signed [AW:0] w_shf;

    // Add half an output LSB, arithmetic shift, then clamp.
    always_comb begin
        w_rnd = {i_acc[AW-1], i_acc} + HALF;
        w_shf = w_rnd >>> FRAC;
        o_sat = 1'b0;
        o_dat = w_shf[N-1:0];
        if (w_shf > MAXV) begin
            o_dat = MAXV[N-1:0];
            o_sat = 1'b1;
        end else if (w_shf < MINV) begin
            o_dat = MINV[N-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/fir_filter_param.sv
// Streaming direct-form FIR with run-time coefficients, rounding, saturation and bypass.
// Latency: 3 cycles from an accepted sample to out_valid; one sample per cycle.
// Backpressure: none; gaps on in_valid propagate as gaps on out_valid.
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int N    = 16,
    parameter int CW   = 16,
    parameter int FRAC = 14,
    parameter int TAPS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic signed [N-1:0]       data_in,
    input  logic                      bypass,
    input  logic                      coef_we,
    input  logic [clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [CW-1:0]      coef_data,
    output logic                      out_valid,
    output logic signed [N-1:0]       data_out,
    output logic                      sat_flag
);

    localparam int PW = N + CW;
    localparam int AW = acc_width(N, CW, TAPS);
    localparam logic signed [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1} << FRAC;

    logic signed [N-1:0]  r_x    [TAPS];
    logic signed [CW-1:0] r_c    [TAPS];
    logic signed [PW-1:0] r_prod [TAPS];
    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] w_sum;

    // Valid and bypass travel with each sample: [0] delay line, [1] S1, [2] S2.
    logic [2:0]           r_vld;
    logic [2:0]           r_byp;
    logic signed [N-1:0]  r_bdat1;
    logic signed [N-1:0]  r_bdat2;

    logic signed [N-1:0]  w_rs_dat;
    logic                 w_rs_sat;

    // Delay line shifts only when a sample is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
            end
        end else if (in_valid) begin
            r_x[0] <= data_in;
            for (int k = 1; k < TAPS; k++) begin
                r_x[k] <= r_x[k-1];
            end
        end
    end

    // Coefficient file: identity on reset, out-of-range addresses dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_c[k] <= (k == 0) ? C_ONE : '0;
            end
        end else if (coef_we && (int'(coef_addr) < TAPS)) begin
            r_c[coef_addr] <= coef_data;
        end
    end

    // S1: one full-precision product per tap.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_prod[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                r_prod[k] <= PW'(r_x[k]) * PW'(r_c[k]);
            end
        end
    end

    // Adder tree over sign-extended products; width chosen so it cannot overflow.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            w_sum = w_sum + AW'(r_prod[k]);
        end
    end

    // S2: register the accumulated sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_sum;
        end
    end

    // Valid/bypass/raw-sample pipe aligned with the arithmetic stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld   <= '0;
            r_byp   <= '0;
            r_bdat1 <= '0;
            r_bdat2 <= '0;
        end else begin
            r_vld   <= {r_vld[1:0], in_valid};
            r_byp   <= {r_byp[1:0], bypass};
            r_bdat1 <= r_x[0];
            r_bdat2 <= r_bdat1;
        end
    end

    fir_round_sat #(
        .AW   (AW),
        .N    (N),
        .FRAC (FRAC)
    ) u_round_sat (
        .i_acc (r_acc),
        .o_dat (w_rs_dat),
        .o_sat (w_rs_sat)
    );

    // S3: output register; data holds across bubbles, saturation is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= r_vld[2];
            if (r_vld[2]) begin
                data_out <= r_byp[2] ? r_bdat2 : w_rs_dat;
                if (!r_byp[2] && w_rs_sat) begin
                    sat_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_filter_param.sv
// Scoreboard bench for fir_filter_param with directed, hand-computed vectors.
// Latency: checks each output arrives exactly 3 cycles after its sample.
// Backpressure: none exercised; gaps on in_valid are.
module tb_fir_filter_param;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic signed [15:0] data_in;
    logic               bypass;
    logic               coef_we;
    logic [1:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic               out_valid;
    logic signed [15:0] data_out;
    logic               sat_flag;

    typedef struct {
        logic signed [15:0] d;
        int                 c;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    fir_filter_param #(
        .N    (16),
        .CW   (16),
        .FRAC (14),
        .TAPS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .bypass    (bypass),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .data_out  (data_out),
        .sat_flag  (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: every presented output must match the oldest expectation and its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected cyc=%0d data_out=%0d required=no output", cyc, data_out);
            end else begin
                e = q.pop_front();
                if (data_out !== e.d || cyc != e.c) begin
                    bad++;
                    $display("FAIL out_data cyc=%0d data_out=%0d required data=%0d at cyc=%0d",
                             cyc, data_out, e.d, e.c);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic smp(input logic signed [15:0] d, input logic b, input logic signed [15:0] e);
        exp_t x;
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = d;
        bypass   = b;
        coef_we  = 1'b0;
        x.d = e;
        x.c = cyc + 4;
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            coef_we  = 1'b0;
        end
    endtask

    task automatic wc(input logic [1:0] a, input logic signed [15:0] d);
        @(negedge clk);
        in_valid  = 1'b0;
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_sat_flag", int'(sat_flag), 0);
    endtask

    logic        gap_v [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int          gap_d [7] = '{10, 0, 0, 20, 30, 0, 40};
    int          gap_s [7] = '{10, 0, 0, 30, 50, 0, 70};

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        bypass    = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // Identity impulse.
        smp(16'sd100, 1'b0, 16'sd100);
        repeat (3) smp(16'sd0, 1'b0, 16'sd0);
        idle(4);
        chk("ident_sat", int'(sat_flag), 0);

        // 4-tap moving average step response.
        do_reset();
        for (int k = 0; k < 4; k++) wc(2'(k), 16'sd4096);
        smp(16'sd1000, 1'b0, 16'sd250);
        smp(16'sd1000, 1'b0, 16'sd500);
        smp(16'sd1000, 1'b0, 16'sd750);
        smp(16'sd1000, 1'b0, 16'sd1000);
        smp(16'sd1000, 1'b0, 16'sd1000);
        idle(4);

        // Saturation and sticky flag.
        do_reset();
        wc(2'd0, 16'sd16384);
        wc(2'd1, 16'sd16384);
        smp(16'sd30000, 1'b0, 16'sd30000);
        smp(16'sd30000, 1'b0, 16'sd32767);
        idle(4);
        chk("sat_set", int'(sat_flag), 1);
        smp(-16'sd30000, 1'b0, 16'sd0);
        smp(-16'sd30000, 1'b0, -16'sd32768);
        smp(16'sd0, 1'b0, -16'sd30000);
        idle(4);
        chk("sat_sticky", int'(sat_flag), 1);

        // Round half-up.
        do_reset();
        wc(2'd0, 16'sd8192);
        smp(16'sd3, 1'b0, 16'sd2);
        smp(-16'sd3, 1'b0, -16'sd1);
        smp(-16'sd4, 1'b0, -16'sd2);
        idle(4);
        chk("round_sat", int'(sat_flag), 0);

        // Gapped input, identity then 2-tap sum.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (gap_v[i]) smp(16'(gap_d[i]), 1'b0, 16'(gap_d[i]));
            else          idle(1);
        end
        idle(4);
        do_reset();
        wc(2'd0, 16'sd16384);
        wc(2'd1, 16'sd16384);
        for (int i = 0; i < 7; i++) begin
            if (gap_v[i]) smp(16'(gap_d[i]), 1'b0, 16'(gap_s[i]));
            else          idle(1);
        end
        idle(4);

        // Bypass on samples 3-5 of a 2-tap average; line keeps shifting.
        do_reset();
        wc(2'd0, 16'sd8192);
        wc(2'd1, 16'sd8192);
        smp(16'sd100, 1'b0, 16'sd50);
        smp(16'sd200, 1'b0, 16'sd150);
        smp(16'sd300, 1'b1, 16'sd300);
        smp(16'sd400, 1'b1, 16'sd400);
        smp(16'sd500, 1'b1, 16'sd500);
        smp(16'sd600, 1'b0, 16'sd550);
        idle(4);

        // Reset with two samples in flight; reset beats in_valid and coef_we.
        wc(2'd0, 16'sd5000);
        @(negedge clk);
        coef_we  = 1'b0;
        in_valid = 1'b1;
        data_in  = 16'sd1111;
        @(negedge clk);
        data_in  = 16'sd2222;
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b1;
        data_in   = 16'sd777;
        coef_we   = 1'b1;
        coef_addr = 2'd0;
        coef_data = 16'sd0;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        chk("midrst_out_valid", int'(out_valid), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst_quiet", int'(out_valid), 0);
        end
        smp(16'sd100, 1'b0, 16'sd100);
        smp(16'sd0, 1'b0, 16'sd0);
        idle(2);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("drain_left", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
